instr_loader_enc: RTL and testbench

//  Inverse of the main control decoder: accepts symbolic instruction requests (class, registers, immediate)

---
 rtl/instr_loader_enc.sv | 159 +++++++++++++++
 tb/tb_instr_loader_enc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader_enc.sv
// Boot/debug instruction loader: encodes symbolic instruction requests into MIPS words
// and streams them into imem through the load port during a start/finish-bounded session.
module instr_loader_enc #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [25:0]       in_imm,
    output logic              we_im,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [2:0] C_RTYPE = 3'd0;
    localparam logic [2:0] C_ADDI  = 3'd1;
    localparam logic [2:0] C_BEQ   = 3'd2;
    localparam logic [2:0] C_J     = 3'd3;
    localparam logic [2:0] C_JAL   = 3'd4;
    localparam logic [2:0] C_SW    = 3'd5;
    localparam logic [2:0] C_LW    = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wd_q, im_wd_d;
    logic                we_im_q, we_im_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;
    logic                legal;
    logic [31:0]         enc_word;

    // Only RTYPE beats can be illegal; every other class always encodes.
    always_comb begin
        legal = 1'b1;
        if (in_class == C_RTYPE) begin
            case (in_funct)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08: legal = 1'b1;
                default:                                   legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        enc_word = 32'h0;
        case (in_class)
            C_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, in_funct};
            C_ADDI:  enc_word = {OP_ADDI, in_rs, in_rt, in_imm[15:0]};
            C_BEQ:   enc_word = {OP_BEQ,  in_rs, in_rt, in_imm[15:0]};
            C_SW:    enc_word = {OP_SW,   in_rs, in_rt, in_imm[15:0]};
            C_LW:    enc_word = {OP_LW,   in_rs, in_rt, in_imm[15:0]};
            C_J:     enc_word = {OP_J,   in_imm};
            C_JAL:   enc_word = {OP_JAL, in_imm};
            default: enc_word = 32'h0;
        endcase
    end

    assign in_ready = busy_q & (count_q < DEPTH_C) & ~finish;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        im_addr_d = im_addr_q;
        im_wd_d   = im_wd_q;
        err_d     = err_q;
        we_im_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (legal) begin
                        we_im_d   = 1'b1;
                        im_addr_d = count_q[ADDR_W-1:0];
                        im_wd_d   = enc_word;
                        count_d   = count_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (finish || (count_q == DEPTH_C)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            im_addr_q <= '0;
            im_wd_q   <= '0;
            we_im_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            im_addr_q <= im_addr_d;
            im_wd_q   <= im_wd_d;
            we_im_q   <= we_im_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign we_im   = we_im_q;
    assign im_addr = im_addr_q;
    assign im_wd   = im_wd_q;
    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_instr_loader_enc.sv
// Scoreboard bench for instr_loader_enc: directed beats push expected imem writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_instr_loader_enc;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [25:0]       in_imm;
    logic              we_im;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wd;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;

    instr_loader_enc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
        .we_im(we_im), .im_addr(im_addr), .im_wd(im_wd), .count(count),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every imem write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && we_im) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", im_addr, im_wd);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(im_addr), 32'(e[ADDR_W+31:32]));
                chk("write_data", im_wd, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        exp_addr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Presents one beat and holds it until accepted (bounded); leaves in_valid high.
    task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] f, input logic [25:0] imm,
                        input bit wr, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f; in_imm = imm;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (wr) begin
                    exp_q.push_back({exp_addr, wd});
                    exp_addr = exp_addr + ADDR_W'(1);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 8 cycles, expected accept");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int acc;
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
        exp_addr = '0;
        tick(); tick();
        chk("rst_we_im", 32'(we_im), 0);
        chk("rst_addr", 32'(im_addr), 0);
        chk("rst_wd", im_wd, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", {28'h0, busy, done, err, in_ready}, 0);
        rst = 1'b0;
        tick();

        // Single ADDI
        pulse_start();
        chk("start_busy", 32'(busy), 1);
        send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 26'd5, 1'b1, 32'h2008_0005);
        idle();
        chk("addi_we", 32'(we_im), 1);
        chk("addi_count", 32'(count), 1);
        tick();
        pulse_finish();
        chk("finish_done", {30'h0, busy, done}, 32'h1);

        // RTYPE, LW, SW back-to-back, then an illegal funct
        pulse_start();
        chk("restart_count", 32'(count), 0);
        send(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 26'd0, 1'b1, 32'h0109_5020);
        send(3'd6, 5'd8, 5'd9, 5'd0, 6'd0, 26'd4, 1'b1, 32'h8D09_0004);
        send(3'd5, 5'd8, 5'd9, 5'd0, 6'd0, 26'd4, 1'b1, 32'hAD09_0004);
        idle();
        tick();
        chk("b2b_count", 32'(count), 3);
        send(3'd0, 5'd8, 5'd9, 5'd10, 6'h3F, 26'd0, 1'b0, 32'h0);
        idle();
        tick();
        chk("bad_funct_count", 32'(count), 3);
        chk("bad_funct_err", 32'(err), 1);
        pulse_finish();
        chk("err_sticky_done", {30'h0, done, err}, 32'h3);

        // Four beats reach DEPTH and end the session by themselves
        pulse_start();
        chk("start_clears_err", 32'(err), 0);
        send(3'd2, 5'd8, 5'd9, 5'd0, 6'd0, 26'h0FFFF, 1'b1, 32'h1109_FFFF);
        send(3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 26'h10, 1'b1, 32'h0800_0010);
        send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 26'h10, 1'b1, 32'h0C00_0010);
        send(3'd7, 5'd3, 5'd4, 5'd5, 6'd0, 26'h3FF, 1'b1, 32'h0000_0000);
        chk("full_in_ready", 32'(in_ready), 0);
        idle();
        tick();
        chk("full_done", {30'h0, busy, done}, 32'h1);

        // Stream six beats into a DEPTH=4 session
        pulse_start();
        for (int i = 0; i < 4; i++) exp_q.push_back({ADDR_W'(i), 32'h2022_1234});
        acc = 0;
        in_valid = 1'b1;
        in_class = 3'd1; in_rs = 5'd1; in_rt = 5'd2; in_imm = 26'h1234;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        idle();
        chk("stream_accepts", 32'(acc), 4);
        chk("stream_count", 32'(count), 4);
        chk("stream_done", {30'h0, done, in_ready}, 32'h2);

        // finish with in_valid: no accept, in-flight write still lands
        pulse_start();
        send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 26'd5, 1'b1, 32'h2008_0005);
        finish = 1'b1;
        #1;
        chk("finish_in_ready", 32'(in_ready), 0);
        tick();
        finish = 1'b0;
        idle();
        chk("finish_valid_done", 32'(done), 1);
        chk("finish_valid_count", 32'(count), 1);
        tick();
        chk("done_no_we", 32'(we_im), 0);

        // Asynchronous reset mid-session abandons the pending write
        pulse_start();
        send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 26'd7, 1'b1, 32'h2008_0007);
        idle();
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_we", 32'(we_im), 0);
        chk("async_rst_out", {im_wd[30:0], busy}, 0);
        chk("async_rst_count", 32'(count), 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 26'd9, 1'b1, 32'h2008_0009);
        idle();
        tick();
        chk("resume_count", 32'(count), 1);

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
